// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
//   arb_state_e : arbiter FSM state (idle / owner holds the write port)
//   idx_width() : bit width needed to index n items (at least 1)
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of producer-side and FIFO-side signals around the write arbiter.
//   req / req_data            : producer requests and their words (packed, producer i at i*W)
//   gnt                       : one-hot grant back to producers (combinational)
//   fifo_data_in / fifo_wr_en : registered write toward the FIFO
//   fifo_full / almostfull / wr_ack / overflow : FIFO status back into the arbiter
//   owner / busy / wr_count / err_overflow / err_ack_miss : arbiter status
// Modport slave is the arbiter's view; master is the environment (producers + FIFO).
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned FIFO_WIDTH = 16
);
    localparam int unsigned IdxW = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic [FIFO_WIDTH-1:0]         fifo_data_in;
    logic                          fifo_wr_en;
    logic                          fifo_full;
    logic                          fifo_almostfull;
    logic                          fifo_wr_ack;
    logic                          fifo_overflow;
    logic [IdxW-1:0]               owner;
    logic                          busy;
    logic [31:0]                   wr_count;
    logic                          err_overflow;
    logic                          err_ack_miss;

    modport slave (
        input  req, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
        output gnt, fifo_data_in, fifo_wr_en, owner, busy, wr_count, err_overflow,
               err_ack_miss
    );

    modport master (
        output req, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
        input  gnt, fifo_data_in, fifo_wr_en, owner, busy, wr_count, err_overflow,
               err_ack_miss
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   i_req   : request vector
//   i_start : index with highest priority; priority falls off going upward, wrapping
//   o_valid : at least one request present
//   o_idx   : first requesting index at or after i_start
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_start,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    logic [IDX_W-1:0] w_cand;

    // Walk from lowest to highest priority so the last hit wins.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            w_cand = IDX_W'((32'(i_start) + 32'(k)) % NUM_REQ);
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NUM_REQ producers.
// Takes at most one word per cycle from the granted producer, registers it as a FIFO
// write, throttles on full/almostfull, counts acknowledged writes and latches sticky
// error flags for missing acks and FIFO overflow.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fifo_wr_arbiter_if slave view (producers, FIFO write port, status)
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned MAX_BURST  = 4
) (
    input logic              clk,
    input logic              rst,
    fifo_wr_arbiter_if.slave bus
);

    localparam int unsigned     IdxW       = idx_width(NUM_REQ);
    localparam int unsigned     CntW       = idx_width(MAX_BURST + 1);
    localparam logic [IdxW-1:0] LastIdx    = IdxW'(NUM_REQ - 1);
    localparam logic [CntW-1:0] BurstMax   = CntW'(MAX_BURST);
    localparam logic [CntW-1:0] BurstOne   = CntW'(1);
    localparam bit              SingleBeat = (MAX_BURST == 1);

    arb_state_e            r_state, w_state_d;
    logic [IdxW-1:0]       r_owner, w_owner_d;
    logic [IdxW-1:0]       r_last_owner, w_last_owner_d;
    logic [CntW-1:0]       r_beat_cnt, w_beat_cnt_d;

    logic                  r_wr_en;
    logic                  r_ack_due;
    logic [FIFO_WIDTH-1:0] r_data;
    logic [31:0]           r_wr_count;
    logic                  r_err_overflow;
    logic                  r_err_ack_miss;

    logic                  w_can_write;
    logic                  w_release;
    logic [NUM_REQ-1:0]    w_owner_oh;
    logic [NUM_REQ-1:0]    w_pick_req;
    logic [IdxW-1:0]       w_base;
    logic [IdxW-1:0]       w_start;
    logic                  w_pick_valid;
    logic [IdxW-1:0]       w_pick_idx;
    logic                  w_grant;
    logic [IdxW-1:0]       w_grant_idx;
    logic [FIFO_WIDTH-1:0] w_grant_data;

    // A write already in flight will fill an almost-full FIFO, so hold off one cycle.
    assign w_can_write = !bus.fifo_full && !(bus.fifo_almostfull && r_wr_en);

    // Owner gives up the port when it stops requesting or has used its burst.
    assign w_release  = (r_state == ARB_OWN) &&
                        (!bus.req[r_owner] || (r_beat_cnt >= BurstMax));
    assign w_owner_oh = NUM_REQ'(1) << r_owner;

    // On release the same-cycle re-pick excludes the outgoing owner and starts after it,
    // which is what lets ownership rotate without a bubble.
    assign w_pick_req = w_release ? (bus.req & ~w_owner_oh) : bus.req;
    assign w_base     = w_release ? r_owner : r_last_owner;
    assign w_start    = (w_base == LastIdx) ? '0 : w_base + IdxW'(1);

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IdxW)
    ) u_picker (
        .i_req   (w_pick_req),
        .i_start (w_start),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_owner      <= '0;
            r_last_owner <= LastIdx;
            r_beat_cnt   <= '0;
        end else begin
            r_state      <= w_state_d;
            r_owner      <= w_owner_d;
            r_last_owner <= w_last_owner_d;
            r_beat_cnt   <= w_beat_cnt_d;
        end
    end

    // Next-state and grant decision
    always_comb begin
        w_state_d      = r_state;
        w_owner_d      = r_owner;
        w_last_owner_d = r_last_owner;
        w_beat_cnt_d   = r_beat_cnt;
        w_grant        = 1'b0;
        w_grant_idx    = r_owner;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid && w_can_write) begin
                    w_grant      = 1'b1;
                    w_grant_idx  = w_pick_idx;
                    w_owner_d    = w_pick_idx;
                    w_beat_cnt_d = BurstOne;
                    // A one-beat burst is already complete, so rotate straight away.
                    if (SingleBeat) begin
                        w_last_owner_d = w_pick_idx;
                    end else begin
                        w_state_d = ARB_OWN;
                    end
                end
            end
            ARB_OWN: begin
                if (!w_release) begin
                    if (w_can_write) begin
                        w_grant      = 1'b1;
                        w_grant_idx  = r_owner;
                        w_beat_cnt_d = r_beat_cnt + BurstOne;
                    end
                end else begin
                    w_last_owner_d = r_owner;
                    if (w_pick_valid && w_can_write) begin
                        w_grant      = 1'b1;
                        w_grant_idx  = w_pick_idx;
                        w_owner_d    = w_pick_idx;
                        w_beat_cnt_d = BurstOne;
                    end else begin
                        w_state_d = ARB_IDLE;
                    end
                end
            end
        endcase
    end

    // Outputs: grant vector and the word it selects
    always_comb begin
        bus.gnt      = '0;
        w_grant_data = bus.req_data[32'(w_grant_idx) * FIFO_WIDTH +: FIFO_WIDTH];
        // Grant is combinational; force it low while reset is held.
        if (w_grant && !rst) begin
            bus.gnt[w_grant_idx] = 1'b1;
        end
    end

    // Write port, ack bookkeeping and sticky errors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en        <= 1'b0;
            r_ack_due      <= 1'b0;
            r_data         <= '0;
            r_wr_count     <= '0;
            r_err_overflow <= 1'b0;
            r_err_ack_miss <= 1'b0;
        end else begin
            r_wr_en   <= w_grant;
            r_ack_due <= r_wr_en;
            if (w_grant) begin
                r_data <= w_grant_data;
            end
            if (bus.fifo_wr_ack) begin
                r_wr_count <= r_wr_count + 32'd1;
            end
            if (bus.fifo_overflow) begin
                r_err_overflow <= 1'b1;
            end
            if (r_ack_due && !bus.fifo_wr_ack) begin
                r_err_ack_miss <= 1'b1;
            end
        end
    end

    assign bus.fifo_wr_en   = r_wr_en;
    assign bus.fifo_data_in = r_data;
    assign bus.owner        = r_owner;
    assign bus.busy         = (r_state == ARB_OWN);
    assign bus.wr_count     = r_wr_count;
    assign bus.err_overflow = r_err_overflow;
    assign bus.err_ack_miss = r_err_ack_miss;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: producers and a depth-8 FIFO are modelled here,
// and a rule-level reference predicts every grant and registered output.
module tb_fifo_wr_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned W     = 16;
    localparam int unsigned MB    = 4;
    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .FIFO_WIDTH(W)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .FIFO_WIDTH (W),
        .MAX_BURST  (MB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Producers
    logic [N-1:0] p_req;
    logic [W-1:0] p_word [N];
    int           req_pct, rerq_pct, rd_pct;

    // FIFO environment
    int fifo_cnt;
    bit ack_pend;
    bit nack_armed, ovf_armed, rd_once;

    // Reference model
    bit          m_busy;
    int          m_owner, m_last, m_beats;
    bit          e_wr_en, e_prev_wr_en;
    logic [W-1:0] e_data;
    logic [31:0] e_wr_count;
    bit          e_err_ovf, e_err_miss;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy       = 0;
        m_owner      = 0;
        m_last       = N - 1;
        m_beats      = 0;
        e_wr_en      = 0;
        e_prev_wr_en = 0;
        e_data       = '0;
        e_wr_count   = '0;
        e_err_ovf    = 0;
        e_err_miss   = 0;
        fifo_cnt     = 0;
        ack_pend     = 0;
    endtask

    task automatic check_regs();
        check("fifo_wr_en", bus.fifo_wr_en, e_wr_en);
        check("fifo_data_in", bus.fifo_data_in, e_data);
        check("owner", bus.owner, m_owner);
        check("busy", bus.busy, m_busy);
        check("wr_count", bus.wr_count, e_wr_count);
        check("err_overflow", bus.err_overflow, e_err_ovf);
        check("err_ack_miss", bus.err_ack_miss, e_err_miss);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check({tag, "_gnt"}, bus.gnt, 0);
        check({tag, "_wr_en"}, bus.fifo_wr_en, 0);
        check({tag, "_data"}, bus.fifo_data_in, 0);
        check({tag, "_owner"}, bus.owner, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_wr_count"}, bus.wr_count, 0);
        check({tag, "_err_ovf"}, bus.err_overflow, 0);
        check({tag, "_err_miss"}, bus.err_ack_miss, 0);
        model_reset();
        @(negedge clk);
        bus.req             = '0;
        bus.fifo_full       = 1'b0;
        bus.fifo_almostfull = 1'b0;
        bus.fifo_wr_ack     = 1'b0;
        bus.fifo_overflow   = 1'b0;
        rst                 = 1'b0;
    endtask

    task automatic cycle();
        bit           cw, rd, ack, ovf, rel, cur_wr_en;
        int           g, c;
        logic [N-1:0] exp_gnt;
        @(negedge clk);
        bus.req = p_req;
        for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = p_word[i];
        bus.fifo_full       = (fifo_cnt == DEPTH);
        bus.fifo_almostfull = (fifo_cnt == DEPTH - 1);
        ack = ack_pend;
        if (ack_pend && nack_armed) begin
            ack        = 0;
            nack_armed = 0;
        end
        ovf       = ovf_armed;
        ovf_armed = 0;
        bus.fifo_wr_ack   = ack;
        bus.fifo_overflow = ovf;
        rd      = rd_once || ($urandom_range(99) < rd_pct);
        rd_once = 0;
        #1;
        check_regs();

        // Expected grant from the arbitration rules
        cw = (fifo_cnt != DEPTH) && !((fifo_cnt == DEPTH - 1) && e_wr_en);
        g  = -1;
        if (m_busy && p_req[m_owner] && m_beats < MB) begin
            if (cw) begin
                g = m_owner;
                m_beats++;
            end
        end else begin
            rel = m_busy;
            if (rel) m_last = m_owner;
            c = -1;
            for (int k = 1; k <= N; k++) begin
                int cand = (m_last + k) % N;
                if (c < 0 && p_req[cand] && !(rel && cand == m_owner)) c = cand;
            end
            if (c >= 0 && cw) begin
                g       = c;
                m_owner = c;
                m_beats = 1;
                if (MB == 1) m_last = c;
                else m_busy = 1;
            end else begin
                m_busy = 0;
            end
        end
        exp_gnt = (g >= 0) ? (N'(1) << g) : '0;
        check("gnt", bus.gnt, exp_gnt);
        cur_wr_en = bus.fifo_wr_en;
        if (cur_wr_en) check("fifo_room", fifo_cnt < DEPTH, 1);

        @(posedge clk);
        // FIFO environment
        ack_pend = cur_wr_en && (fifo_cnt < DEPTH);
        fifo_cnt = fifo_cnt + (ack_pend ? 1 : 0) - ((rd && fifo_cnt > 0) ? 1 : 0);
        // Expected registered outputs
        e_err_miss   = e_err_miss || (e_prev_wr_en && !ack);
        e_err_ovf    = e_err_ovf || ovf;
        if (ack) e_wr_count++;
        e_prev_wr_en = e_wr_en;
        e_wr_en      = (g >= 0);
        if (g >= 0) e_data = p_word[g];
        // Producers: a request stays up with stable data until it is granted
        if (g >= 0) begin
            p_req[g]  = ($urandom_range(99) < rerq_pct);
            p_word[g] = W'($urandom);
        end
        for (int i = 0; i < N; i++) begin
            if (!p_req[i] && i != g && $urandom_range(99) < req_pct) begin
                p_req[i]  = 1'b1;
                p_word[i] = W'($urandom);
            end
        end
    endtask

    initial begin
        bus.req             = '0;
        bus.req_data        = '0;
        bus.fifo_full       = 1'b0;
        bus.fifo_almostfull = 1'b0;
        bus.fifo_wr_ack     = 1'b0;
        bus.fifo_overflow   = 1'b0;
        p_req               = '0;
        for (int i = 0; i < N; i++) p_word[i] = '0;
        req_pct    = 0;
        rerq_pct   = 0;
        rd_pct     = 0;
        nack_armed = 0;
        ovf_armed  = 0;
        rd_once    = 0;
        model_reset();
        apply_reset("rst0");

        // Two steady producers, no reads: burst of 4 to 0, then 2, until the FIFO fills
        p_req = 4'b0101;
        for (int i = 0; i < N; i++) p_word[i] = W'($urandom);
        rerq_pct = 100;
        repeat (14) cycle();
        #1;
        check("fill_level", fifo_cnt, DEPTH);
        check("fill_wr_count", bus.wr_count, 8);

        // One read frees one slot: exactly one more write
        rd_once = 1;
        repeat (6) cycle();
        #1;
        check("refill_level", fifo_cnt, DEPTH);
        check("refill_wr_count", bus.wr_count, 9);

        // Random traffic, then a throttle-heavy mix
        rd_pct   = 55;
        req_pct  = 35;
        rerq_pct = 50;
        repeat (1500) cycle();
        rd_pct  = 15;
        req_pct = 70;
        repeat (500) cycle();

        // Reset in the middle of a burst
        apply_reset("rst1");
        p_req    = 4'b0001;
        req_pct  = 0;
        rerq_pct = 100;
        rd_pct   = 100;
        repeat (2) cycle();
        #1;
        check("pre_rst_busy", bus.busy, 1);
        apply_reset("rst_mid");
        p_req = 4'b1111;
        for (int i = 1; i < N; i++) p_word[i] = W'($urandom);
        rerq_pct = 50;
        req_pct  = 50;
        rd_pct   = 50;
        repeat (40) cycle();

        // Missing ack and overflow pulse latch sticky errors
        nack_armed = 1;
        for (int i = 0; i < 200 && nack_armed; i++) cycle();
        ovf_armed = 1;
        repeat (20) cycle();
        #1;
        if (!nack_armed) check("err_ack_miss_held", bus.err_ack_miss, 1);
        check("err_overflow_held", bus.err_overflow, 1);
        apply_reset("rst_err");
        repeat (10) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
